// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg
// Shared definitions for the program-memory responder: responder FSM
// encoding and memory geometry (256 words of 15 bits, 8-bit data lane).
package prog_mem_pkg;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 15;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;

    // LOAD    : loader owns the memory, processor held in reset
    // RELEASE : one settling cycle before the processor is released
    // RUN     : processor owns the memory
    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } mem_state_t;

endpackage

// File: rtl/prog_mem_responder_mem_array.sv
// mem_array
// 256 x 15-bit storage, one asynchronous read port and one synchronous
// write port with two lane enables. Contents are never reset.
//   clk_i      : write clock (rising edge)
//   raddr_i    : read address
//   rdata_o    : read word, combinational from raddr_i
//   waddr_i    : write address
//   wdata_i    : write word
//   we_lo_i    : write enable for bits [7:0]
//   we_hi_i    : write enable for bits [14:8]
module mem_array
    import prog_mem_pkg::*;
(
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              we_lo_i,
    input  logic              we_hi_i
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_lo_i) mem_q[waddr_i][DATA_W-1:0]      <= wdata_i[DATA_W-1:0];
        if (we_hi_i) mem_q[waddr_i][WORD_W-1:DATA_W] <= wdata_i[WORD_W-1:DATA_W];
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_mem_responder.sv
// prog_mem_responder
// Memory-side responder for the 8-bit processor bus. After reset it
// accepts loader words (valid/ready) into a unified 256 x 15 memory while
// holding the processor in reset, then releases the processor and serves
// combinational reads and clocked byte writes.
//
// Optional feature macro: MEM_WP_EN -- when defined, processor writes to
// addresses below WP_LIMIT are dropped and flagged on wp_fault.
//
// Ports:
//   ph1        : clock, rising edge
//   reset      : asynchronous active-high reset
//   MemWrite   : processor write strobe
//   Adr        : processor address
//   MemData1   : instruction high bits [14:8] (0 outside RUN)
//   MemData2   : bidirectional data; driven by us only in RUN with MemWrite=0
//   load_valid / load_ready / load_addr / load_data / load_last : loader port
//   reload     : in RUN, return to LOAD
//   cpu_reset  : registered processor reset
//   word_count : loader words accepted since entering LOAD, saturates at 256
//   wp_fault   : sticky write-protect violation
//   state_o    : current FSM state, for observation
//
// Loader handshake: a word transfers on a ph1 edge where load_valid and
// load_ready are both high. load_ready depends on state only; the loader
// may hold load_valid high across words and the responder never stalls
// inside LOAD.
module prog_mem_responder
    import prog_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] WP_LIMIT = 8'h80
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Adr,
    output logic [6:0]        MemData1,
    inout  wire  [DATA_W-1:0] MemData2,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    input  logic              reload,
    output logic              cpu_reset,
    output logic [8:0]        word_count,
    output logic              wp_fault,
    output mem_state_t        state_o
);

    localparam logic [8:0] COUNT_MAX = 9'd256;

    mem_state_t        state_q, state_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic [8:0]        count_q, count_d;
    logic              wp_fault_q, wp_fault_d;

    logic              in_run;
    logic              load_hs;
    logic              cpu_wr;
    logic              wp_hit;
    logic              md2_oe;
    logic [WORD_W-1:0] rdata;
    logic [ADDR_W-1:0] waddr;
    logic [WORD_W-1:0] wdata;
    logic              we_lo, we_hi;

    assign in_run     = (state_q == ST_RUN);
    assign load_ready = (state_q == ST_LOAD);
    assign load_hs    = load_valid & load_ready;

`ifdef MEM_WP_EN
    assign wp_hit = in_run & MemWrite & (Adr < WP_LIMIT);
`else
    logic unused_wp_limit;
    assign unused_wp_limit = ^WP_LIMIT;
    assign wp_hit          = 1'b0;
`endif

    // Processor write proceeds in RUN even when reload is high this cycle.
    assign cpu_wr = in_run & MemWrite & ~wp_hit;

    // Next-state, counter and flag logic
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wp_fault_d = wp_fault_q | wp_hit;
        case (state_q)
            ST_LOAD: begin
                if (load_hs) begin
                    if (count_q != COUNT_MAX) count_d = count_q + 9'd1;
                    if (load_last) state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (reload) begin
                    state_d    = ST_LOAD;
                    count_d    = 9'd0;
                    wp_fault_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        // Registered so the processor sees a glitch-free reset that falls
        // one edge after the FSM leaves RELEASE's entry edge.
        cpu_reset_d = (state_d != ST_RUN);
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            cpu_reset_q <= 1'b1;
            count_q     <= 9'd0;
            wp_fault_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_reset_q <= cpu_reset_d;
            count_q     <= count_d;
            wp_fault_q  <= wp_fault_d;
        end
    end

    // Write muxing: loader writes whole words, the processor only the low byte.
    // The two sources are exclusive by state.
    always_comb begin
        waddr = Adr;
        wdata = {7'd0, MemData2};
        we_lo = 1'b0;
        we_hi = 1'b0;
        if (load_hs) begin
            waddr = load_addr;
            wdata = load_data;
            we_lo = 1'b1;
            we_hi = 1'b1;
        end else if (cpu_wr) begin
            we_lo = 1'b1;
        end
    end

    mem_array u_mem (
        .clk_i   (ph1),
        .raddr_i (Adr),
        .rdata_o (rdata),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .we_lo_i (we_lo),
        .we_hi_i (we_hi)
    );

    assign md2_oe   = in_run & ~MemWrite;
    assign MemData1 = in_run ? rdata[WORD_W-1:DATA_W] : 7'd0;
    assign MemData2 = md2_oe ? rdata[DATA_W-1:0] : {DATA_W{1'bz}};

    assign cpu_reset  = cpu_reset_q;
    assign word_count = count_q;
    assign wp_fault   = wp_fault_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_prog_mem_responder.sv
module tb_prog_mem_responder;
    import prog_mem_pkg::*;

    // clock / reset
    logic ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    logic        reset;
    logic        MemWrite;
    logic [7:0]  Adr;
    logic [6:0]  MemData1;
    wire  [7:0]  MemData2;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_addr;
    logic [14:0] load_data;
    logic        load_last;
    logic        reload;
    logic        cpu_reset;
    logic [8:0]  word_count;
    logic        wp_fault;
    mem_state_t  state_o;

    logic [7:0]  tb_md2;
    logic        tb_md2_en;
    assign MemData2 = tb_md2_en ? tb_md2 : 8'bz;

    prog_mem_responder dut (
        .ph1        (ph1),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .Adr        (Adr),
        .MemData1   (MemData1),
        .MemData2   (MemData2),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_last  (load_last),
        .reload     (reload),
        .cpu_reset  (cpu_reset),
        .word_count (word_count),
        .wp_fault   (wp_fault),
        .state_o    (state_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference memory model
    logic [14:0] mem_m [256];
    logic        known [256];
    logic        exp_wp;

    // scoreboard
    logic [14:0] exp_q [$];
    logic        hi_known_q [$];

`ifdef MEM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    task automatic step();
        @(posedge ph1);
        #1;
    endtask

    // driver tasks
    task automatic load_word(input logic [7:0] a, input logic [14:0] d, input logic last);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        load_last  = last;
        mem_m[a]   = d;
        known[a]   = 1'b1;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        MemWrite  = 1'b1;
        Adr       = a;
        tb_md2    = d;
        tb_md2_en = 1'b1;
        if (WP_ON && a < 8'h80) exp_wp = 1'b1;
        else mem_m[a][7:0] = d;
        step();
        MemWrite  = 1'b0;
        tb_md2_en = 1'b0;
    endtask

    // pushes the expected word, then pops and compares against the bus
    task automatic read_chk(input logic [7:0] a, input string name);
        logic [14:0] e;
        logic        hk;
        MemWrite  = 1'b0;
        tb_md2_en = 1'b0;
        Adr       = a;
        exp_q.push_back(mem_m[a]);
        hi_known_q.push_back(known[a]);
        #1;
        e  = exp_q.pop_front();
        hk = hi_known_q.pop_front();
        n_tests++;
        if (MemData2 !== e[7:0]) begin
            n_fail++;
            $display("FAIL %s lo adr=%h got=%h exp=%h", name, a, MemData2, e[7:0]);
        end
        if (hk) begin
            n_tests++;
            if (MemData1 !== e[14:8]) begin
                n_fail++;
                $display("FAIL %s hi adr=%h got=%h exp=%h", name, a, MemData1, e[14:8]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_tests++;
        if (cpu_reset !== 1'b1 || load_ready !== 1'b1 || word_count !== 9'd0 ||
            MemData1 !== 7'd0 || state_o !== ST_LOAD || wp_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset cpu_reset=%b load_ready=%b wc=%0d md1=%h st=%0d wp=%b exp 1 1 0 00 0 0",
                     cpu_reset, load_ready, word_count, MemData1, state_o, wp_fault);
        end
        n_tests++;
        if (dut.md2_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_md2_z oe=%b exp 0", dut.md2_oe);
        end
        @(negedge ph1);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_load();
        load_word(8'h00, 15'h1234, 1'b0);
        load_word(8'h01, 15'h5A5A, 1'b0);
        load_word(8'h02, 15'h7FFF, 1'b1);
        n_tests++;
        if (word_count !== 9'd3 || cpu_reset !== 1'b1 || load_ready !== 1'b0 ||
            state_o !== ST_RELEASE) begin
            n_fail++;
            $display("FAIL load_release wc=%0d cpu_reset=%b ready=%b st=%0d exp 3 1 0 1",
                     word_count, cpu_reset, load_ready, state_o);
        end
        step();
        n_tests++;
        if (cpu_reset !== 1'b0 || state_o !== ST_RUN || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_run cpu_reset=%b st=%0d ready=%b exp 0 2 0",
                     cpu_reset, state_o, load_ready);
        end
        read_chk(8'h01, "load_rd01");
        read_chk(8'h00, "load_rd00");
        read_chk(8'h02, "load_rd02");
    endtask

    task automatic test_write();
        cpu_write(8'h90, 8'hA5);
        read_chk(8'h90, "write_rd90");
        // loader port is ignored in RUN
        load_word(8'h01, 15'h0000, 1'b0);
        mem_m[1] = 15'h5A5A;
        n_tests++;
        if (word_count !== 9'd3) begin
            n_fail++;
            $display("FAIL load_in_run wc=%0d exp 3", word_count);
        end
        read_chk(8'h01, "load_in_run_rd01");
    endtask

    task automatic test_wp();
        exp_wp = 1'b0;
        cpu_write(8'h02, 8'h3C);
        read_chk(8'h02, "wp_rd02");
        n_tests++;
        if (wp_fault !== exp_wp) begin
            n_fail++;
            $display("FAIL wp_fault got=%b exp=%b", wp_fault, exp_wp);
        end
        cpu_write(8'hA0, 8'h11);
        n_tests++;
        if (wp_fault !== exp_wp) begin
            n_fail++;
            $display("FAIL wp_sticky got=%b exp=%b", wp_fault, exp_wp);
        end
    endtask

    task automatic test_reload();
        // reload together with a write: the write lands
        reload = 1'b1;
        cpu_write(8'h91, 8'h77);
        reload = 1'b0;
        exp_wp = 1'b0;
        n_tests++;
        if (cpu_reset !== 1'b1 || load_ready !== 1'b1 || word_count !== 9'd0 ||
            wp_fault !== 1'b0 || state_o !== ST_LOAD) begin
            n_fail++;
            $display("FAIL reload cpu_reset=%b ready=%b wc=%0d wp=%b st=%0d exp 1 1 0 0 0",
                     cpu_reset, load_ready, word_count, wp_fault, state_o);
        end
        // processor writes are ignored in LOAD
        MemWrite = 1'b1; Adr = 8'h01; tb_md2 = 8'h00; tb_md2_en = 1'b1;
        step();
        MemWrite = 1'b0; tb_md2_en = 1'b0;
        // reload is ignored outside RUN
        reload = 1'b1;
        load_word(8'h20, 15'h0ABC, 1'b1);
        step();
        reload = 1'b0;
        n_tests++;
        if (state_o !== ST_RUN || word_count !== 9'd1 || cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_reload st=%0d wc=%0d cpu_reset=%b exp 2 1 0",
                     state_o, word_count, cpu_reset);
        end
        read_chk(8'h01, "reload_keep01");
        read_chk(8'h91, "reload_wr91");
        read_chk(8'h20, "reload_rd20");
    endtask

    task automatic test_midload_reset();
        reload = 1'b1;
        step();
        reload = 1'b0;
        load_word(8'h10, 15'h1111, 1'b0);
        load_word(8'h11, 15'h2222, 1'b0);
        n_tests++;
        if (word_count !== 9'd2) begin
            n_fail++;
            $display("FAIL midload_count got=%0d exp 2", word_count);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (word_count !== 9'd0 || cpu_reset !== 1'b1 || state_o !== ST_LOAD) begin
            n_fail++;
            $display("FAIL midload_reset wc=%0d cpu_reset=%b st=%0d exp 0 1 0",
                     word_count, cpu_reset, state_o);
        end
        reset = 1'b0;
        step();
        load_word(8'h12, 15'h3333, 1'b1);
        step();
        n_tests++;
        if (state_o !== ST_RUN || word_count !== 9'd1 || cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_reload st=%0d wc=%0d cpu_reset=%b exp 2 1 0",
                     state_o, word_count, cpu_reset);
        end
        read_chk(8'h10, "midload_rd10");
        read_chk(8'h11, "midload_rd11");
        read_chk(8'h12, "midload_rd12");
    endtask

    task automatic test_back_to_back();
        reload = 1'b1;
        step();
        reload = 1'b0;
        // 257 consecutive words: every address once, then address 0 again
        for (int i = 0; i < 257; i++) begin
            logic [7:0] a;
            a = i[7:0];
            load_word(a, 15'($urandom_range(0, 32767)), (i == 256));
            if (i == 254) begin
                n_tests++;
                if (word_count !== 9'd255) begin
                    n_fail++;
                    $display("FAIL b2b_count255 got=%0d exp 255", word_count);
                end
            end
        end
        n_tests++;
        if (word_count !== 9'd256) begin
            n_fail++;
            $display("FAIL b2b_saturate got=%0d exp 256", word_count);
        end
        step();
        read_chk(8'h00, "b2b_dup00");
        for (int k = 0; k < 40; k++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) cpu_write(a, 8'($urandom_range(0, 255)));
            read_chk(a, "b2b_rand");
        end
        n_tests++;
        if (wp_fault !== exp_wp) begin
            n_fail++;
            $display("FAIL b2b_wp got=%b exp=%b", wp_fault, exp_wp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        MemWrite   = 1'b0;
        Adr        = 8'h00;
        load_valid = 1'b0;
        load_addr  = 8'h00;
        load_data  = 15'h0;
        load_last  = 1'b0;
        reload     = 1'b0;
        tb_md2     = 8'h00;
        tb_md2_en  = 1'b0;
        exp_wp     = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = 15'h0;
            known[i] = 1'b0;
        end

        test_reset();
        test_load();
        test_write();
        test_wp();
        test_reload();
        test_midload_reset();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
